// File: rtl/ulight_fifo_timecode_tx_if.sv
// Avalon-MM slave bus used by the host to reach the time-code transmit registers.
interface ulight_fifo_timecode_tx_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/ulight_fifo_timecode_tx.sv
// Host-driven and periodic SpaceWire time-code issue towards the uLight codec.
// Emits a one-cycle tick_in with time_in whenever a code is pending and the link runs.
module ulight_fifo_timecode_tx #(
  parameter int unsigned PERIOD_W       = 24,
  parameter int unsigned DEFAULT_PERIOD = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ulight_fifo_timecode_tx_if.slave  bus,
  input  logic                      link_run,
  output logic                      tick_in,
  output logic [7:0]                time_in
);

  localparam int unsigned DATA_W = 32;

  logic [7:0]          next_tc;
  logic                pending;
  logic                overrun;
  logic                auto_en;
  logic                auto_inc;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0]          sent_cnt;

  logic                wr_c, wr_data_c, wr_ctrl_c, wr_period_c, wr_status_c;
  logic                auto_run_c, fire_c, tx_c, busy_c, ovr_set_c;
  logic [PERIOD_W-1:0] reload_c;
  logic [DATA_W-1:0]   rd_mux_c;

  // Event decode; busy means a code is still waiting after this cycle's transmit.
  always_comb begin
    wr_c        = bus.chipselect & ~bus.write_n;
    wr_data_c   = wr_c & (bus.address == 2'd0);
    wr_ctrl_c   = wr_c & (bus.address == 2'd1);
    wr_period_c = wr_c & (bus.address == 2'd2);
    wr_status_c = wr_c & (bus.address == 2'd3);
    auto_run_c  = auto_en & (period != '0);
    fire_c      = auto_run_c & (cnt == '0);
    tx_c        = pending & link_run & ~tick_in;
    busy_c      = pending & ~tx_c;
    ovr_set_c   = (wr_data_c & (busy_c | fire_c)) | (fire_c & busy_c);
    reload_c    = (period == '0) ? '0 : period - PERIOD_W'(1);
  end

  // Read mux reflects register state before any same-cycle write.
  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      2'd0: rd_mux_c = {24'b0, time_in};
      2'd1: rd_mux_c = {30'b0, auto_inc, auto_en};
      2'd2: rd_mux_c = DATA_W'(period);
      2'd3: rd_mux_c = {15'b0, overrun, sent_cnt, 6'b0, link_run, pending};
      default: rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      tick_in      <= 1'b0;
      time_in      <= '0;
      next_tc      <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      auto_en      <= 1'b0;
      auto_inc     <= 1'b0;
      period       <= PERIOD_W'(DEFAULT_PERIOD);
      cnt          <= '0;
      sent_cnt     <= '0;
    end else begin
      bus.readdata <= rd_mux_c;
      tick_in      <= tx_c;
      if (tx_c) begin
        time_in  <= next_tc;
        sent_cnt <= sent_cnt + 8'd1;
      end

      // CPU write beats an auto fire; a fire onto a waiting code is dropped.
      if (wr_data_c) begin
        next_tc <= bus.writedata[7:0];
        pending <= 1'b1;
      end else if (fire_c && !busy_c) begin
        pending <= 1'b1;
        if (auto_inc) next_tc <= {time_in[7:6], time_in[5:0] + 6'd1};
      end else if (tx_c) begin
        pending <= 1'b0;
      end

      if (ovr_set_c)                             overrun <= 1'b1;
      else if (wr_status_c && bus.writedata[16]) overrun <= 1'b0;

      if (wr_ctrl_c) begin
        auto_en  <= bus.writedata[0];
        auto_inc <= bus.writedata[1];
      end

      if (wr_ctrl_c && bus.writedata[0] && !auto_en) cnt <= reload_c;
      else if (auto_run_c) cnt <= (cnt == '0) ? reload_c : cnt - PERIOD_W'(1);

      if (wr_period_c) period <= PERIOD_W'(bus.writedata);
    end
  end

endmodule
